// File: rtl/game_pkg.sv
// Shared constants for the memory-game level controller.
//   - FSM state codes, also driven out on the state port.
//   - Feedback tap mask for the 16-bit Fibonacci LFSR (taps 16,14,13,11).
package game_pkg;

    localparam logic [2:0] StIdle  = 3'd0;
    localparam logic [2:0] StGreet = 3'd1;
    localparam logic [2:0] StShow  = 3'd2;
    localparam logic [2:0] StInput = 3'd3;
    localparam logic [2:0] StJudge = 3'd4;
    localparam logic [2:0] StWin   = 3'd5;
    localparam logic [2:0] StLose  = 3'd6;

    // Taps 16,14,13,11 (1-based) map to bits 15,13,12,10 of a left-shifting register.
    localparam logic [15:0] LfsrTaps = 16'hB400;

endpackage

// File: rtl/game_lfsr.sv
// 16-bit Fibonacci LFSR, free-running every clock.
//   clk  : clock
//   rst  : synchronous active-low reset, loads seed
//   seed : reset value (must be nonzero)
//   q    : current register contents
module game_lfsr
    import game_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic [15:0] seed,
    output logic [15:0] q
);

    logic [15:0] r_q;
    logic        w_fb;

    assign w_fb = ^(r_q & LfsrTaps);

    always_ff @(posedge clk) begin
        if (!rst) begin
            r_q <= seed;
        end else begin
            r_q <= {r_q[14:0], w_fb};
        end
    end

    assign q = r_q;

endmodule

// File: rtl/game_level_ctrl.sv
// Memory-game level controller: shows a random target on led, waits for a guess,
// judges it and steps through levels whose target width grows by one bit each.
//   clk, rst       : clock, synchronous active-low reset
//   en             : master enable (0 forces IDLE)
//   start, restart : raw push buttons, acted on at their rising edges
//   guess          : switch value compared against the target
//   led            : masked target while showing, else 0
//   level          : current level (0-based)
//   tries_left     : guesses remaining on the current level
//   state          : FSM state code
//   miss           : one-cycle pulse after a wrong or timed-out guess
//   win, lose      : decoded end states
module game_level_ctrl
    import game_pkg::*;
#(
    parameter int unsigned  NUM_LEVELS     = 3,
    parameter int unsigned  BASE_WIDTH     = 5,
    parameter int unsigned  MAX_TRIES      = 3,
    parameter int unsigned  SHOW_CYCLES    = 50_000_000,
    parameter int unsigned  TIMEOUT_CYCLES = 500_000_000,
    parameter logic [15:0]  SEED           = 16'hACE1,
    localparam int unsigned MAXW           = BASE_WIDTH + NUM_LEVELS - 1,
    localparam int unsigned LW             = (NUM_LEVELS > 1) ? $clog2(NUM_LEVELS) : 1,
    localparam int unsigned TW             = $clog2(MAX_TRIES + 1)
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            en,
    input  logic            start,
    input  logic            restart,
    input  logic [MAXW-1:0] guess,
    output logic [MAXW-1:0] led,
    output logic [LW-1:0]   level,
    output logic [TW-1:0]   tries_left,
    output logic [2:0]      state,
    output logic            miss,
    output logic            win,
    output logic            lose
);

    localparam int unsigned CntMax = (SHOW_CYCLES > TIMEOUT_CYCLES) ? SHOW_CYCLES : TIMEOUT_CYCLES;
    localparam int unsigned CW     = $clog2(CntMax + 1);

    logic            r_start_q, r_restart_q;
    logic            w_start_edge, w_restart_edge, w_restart_ok;
    logic [2:0]      r_state, w_state_d;
    logic [LW-1:0]   r_level, w_level_d;
    logic [TW-1:0]   r_tries, w_tries_d;
    logic [CW-1:0]   r_timer, w_timer_d;
    logic [MAXW-1:0] r_target, w_target_d;
    logic            r_forced, w_forced_d;
    logic            r_miss, w_miss_d;
    logic            w_hit;
    logic [15:0]     w_lfsr;
    logic            w_unused_lfsr;

    game_lfsr u_lfsr (
        .clk  (clk),
        .rst  (rst),
        .seed (SEED),
        .q    (w_lfsr)
    );

    assign w_unused_lfsr = ^w_lfsr[15:MAXW];

    // Bits [BASE_WIDTH+lvl-1:0] are live at level lvl.
    function automatic logic [MAXW-1:0] level_mask(input logic [LW-1:0] lvl);
        logic [MAXW-1:0] m;
        for (int unsigned i = 0; i < MAXW; i++) begin
            m[i] = (i < BASE_WIDTH + 32'(lvl));
        end
        return m;
    endfunction

    // An all-zero live field would be unguessable as "lit"; invert to guarantee nonzero.
    function automatic logic [MAXW-1:0] pick_target(input logic [MAXW-1:0] raw,
                                                    input logic [LW-1:0]   lvl);
        return ((raw & level_mask(lvl)) == '0) ? ~raw : raw;
    endfunction

    assign w_start_edge   = start & ~r_start_q;
    assign w_restart_edge = restart & ~r_restart_q;
    assign w_restart_ok   = (r_state == StGreet) || (r_state == StShow) || (r_state == StInput) ||
                            (r_state == StWin) || (r_state == StLose);
    assign w_hit          = !r_forced && (((guess ^ r_target) & level_mask(r_level)) == '0);

    always_comb begin
        w_state_d  = r_state;
        w_level_d  = r_level;
        w_tries_d  = r_tries;
        w_timer_d  = r_timer;
        w_target_d = r_target;
        w_forced_d = r_forced;
        w_miss_d   = 1'b0;

        if (!en) begin
            w_state_d = StIdle;
        end else if ((w_restart_edge && w_restart_ok) ||
                     (r_state == StGreet && w_start_edge)) begin
            w_state_d  = StShow;
            w_level_d  = '0;
            w_tries_d  = TW'(MAX_TRIES);
            w_target_d = pick_target(w_lfsr[MAXW-1:0], '0);
            w_timer_d  = CW'(SHOW_CYCLES - 1);
        end else begin
            case (r_state)
                StIdle: w_state_d = StGreet;
                StShow: begin
                    if (r_timer == '0) begin
                        w_state_d = StInput;
                        w_timer_d = CW'(TIMEOUT_CYCLES - 1);
                    end else begin
                        w_timer_d = r_timer - CW'(1);
                    end
                end
                StInput: begin
                    if (w_start_edge) begin
                        w_state_d  = StJudge;
                        w_forced_d = 1'b0;
                    end else if (r_timer == '0) begin
                        w_state_d  = StJudge;
                        w_forced_d = 1'b1;
                    end else begin
                        w_timer_d = r_timer - CW'(1);
                    end
                end
                StJudge: begin
                    if (w_hit) begin
                        if (r_level == LW'(NUM_LEVELS - 1)) begin
                            w_state_d = StWin;
                        end else begin
                            w_state_d  = StShow;
                            w_level_d  = r_level + LW'(1);
                            w_tries_d  = TW'(MAX_TRIES);
                            w_target_d = pick_target(w_lfsr[MAXW-1:0], r_level + LW'(1));
                            w_timer_d  = CW'(SHOW_CYCLES - 1);
                        end
                    end else begin
                        w_miss_d  = 1'b1;
                        w_tries_d = r_tries - TW'(1);
                        if (r_tries == TW'(1)) begin
                            w_state_d = StLose;
                        end else begin
                            w_state_d = StShow;
                            w_timer_d = CW'(SHOW_CYCLES - 1);
                        end
                    end
                end
                StGreet, StWin, StLose: w_state_d = r_state;
                default: w_state_d = StIdle;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            r_start_q   <= 1'b0;
            r_restart_q <= 1'b0;
            r_state     <= StIdle;
            r_level     <= '0;
            r_tries     <= TW'(MAX_TRIES);
            r_timer     <= '0;
            r_target    <= '0;
            r_forced    <= 1'b0;
            r_miss      <= 1'b0;
        end else begin
            r_start_q   <= start;
            r_restart_q <= restart;
            r_state     <= w_state_d;
            r_level     <= w_level_d;
            r_tries     <= w_tries_d;
            r_timer     <= w_timer_d;
            r_target    <= w_target_d;
            r_forced    <= w_forced_d;
            r_miss      <= w_miss_d;
        end
    end

    assign led        = (r_state == StShow) ? (r_target & level_mask(r_level)) : '0;
    assign level      = r_level;
    assign tries_left = r_tries;
    assign state      = r_state;
    assign miss       = r_miss;
    assign win        = (r_state == StWin);
    assign lose       = (r_state == StLose);

endmodule

// File: tb/tb_game_level_ctrl.sv
module tb_game_level_ctrl;

    localparam int ShowN    = 4;
    localparam int TimeoutN = 16;
    localparam int Levels   = 3;
    localparam int BaseW    = 5;
    localparam int Tries    = 3;
    localparam int MaxW     = 7;

    logic       clk = 1'b0;
    logic       rst, en, start, restart;
    logic [6:0] guess;
    logic [6:0] led;
    logic [1:0] level;
    logic [1:0] tries_left;
    logic [2:0] state;
    logic       miss, win, lose;

    always #5 clk = ~clk;

    game_level_ctrl #(
        .SHOW_CYCLES    (ShowN),
        .TIMEOUT_CYCLES (TimeoutN)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .en         (en),
        .start      (start),
        .restart    (restart),
        .guess      (guess),
        .led        (led),
        .level      (level),
        .tries_left (tries_left),
        .state      (state),
        .miss       (miss),
        .win        (win),
        .lose       (lose)
    );

    int n_tests = 0;
    int n_fail  = 0;

    // Reference model: game phase codes 0..6, elapsed cycles in the current phase.
    int m_state, m_level, m_tries, m_target, m_lfsr, m_elapsed;
    bit m_forced, m_miss, m_ps, m_pr;
    int seen_led;

    task automatic check_val(input string tag, input int got, input int exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s @%0t: got %0d expected %0d", tag, $time, got, exp);
        end
    endtask

    function automatic int lfsr_next(input int x);
        int fb;
        fb = ((x >> 15) ^ (x >> 13) ^ (x >> 12) ^ (x >> 10)) & 1;
        return ((x << 1) | fb) & 'hFFFF;
    endfunction

    function automatic int pick_target(input int raw, input int lvl);
        int v;
        v = raw % (1 << MaxW);
        if (v % (1 << (BaseW + lvl)) == 0) v = (1 << MaxW) - 1 - v;
        return v;
    endfunction

    task automatic new_game(input int lf);
        m_level   = 0;
        m_tries   = Tries;
        m_target  = pick_target(lf, 0);
        m_state   = 2;
        m_elapsed = 0;
    endtask

    task automatic model_step();
        bit se, re, hit;
        int lf, w;
        if (!rst) begin
            m_state = 0; m_level = 0; m_tries = Tries; m_target = 0;
            m_lfsr = 'hACE1; m_ps = 0; m_pr = 0; m_miss = 0; m_elapsed = 0; m_forced = 0;
        end else begin
            se = start && !m_ps;
            re = restart && !m_pr;
            lf = m_lfsr;
            m_miss = 0;
            if (!en) begin
                m_state = 0;
            end else if (re && m_state != 0 && m_state != 4) begin
                new_game(lf);
            end else begin
                case (m_state)
                    0: m_state = 1;
                    1: if (se) new_game(lf);
                    2: begin
                        m_elapsed++;
                        if (m_elapsed == ShowN) begin m_state = 3; m_elapsed = 0; end
                    end
                    3: begin
                        if (se) begin
                            m_forced = 0; m_state = 4;
                        end else begin
                            m_elapsed++;
                            if (m_elapsed == TimeoutN) begin m_forced = 1; m_state = 4; end
                        end
                    end
                    4: begin
                        w = BaseW + m_level;
                        hit = !m_forced && ((int'(guess) % (1 << w)) == (m_target % (1 << w)));
                        if (hit) begin
                            if (m_level == Levels - 1) begin
                                m_state = 5;
                            end else begin
                                m_level++;
                                m_tries   = Tries;
                                m_target  = pick_target(lf, m_level);
                                m_state   = 2;
                                m_elapsed = 0;
                            end
                        end else begin
                            m_miss = 1;
                            m_tries--;
                            if (m_tries == 0) m_state = 6;
                            else begin m_state = 2; m_elapsed = 0; end
                        end
                    end
                    default: ;
                endcase
            end
            m_ps = start;
            m_pr = restart;
            m_lfsr = lfsr_next(m_lfsr);
        end
    endtask

    task automatic cycle();
        int exp_led;
        @(posedge clk);
        model_step();
        #1;
        exp_led = (m_state == 2) ? m_target % (1 << (BaseW + m_level)) : 0;
        check_val("state", int'(state), m_state);
        check_val("level", int'(level), m_level);
        check_val("tries_left", int'(tries_left), m_tries);
        check_val("led", int'(led), exp_led);
        check_val("miss", int'(miss), int'(m_miss));
        check_val("win", int'(win), int'(m_state == 5));
        check_val("lose", int'(lose), int'(m_state == 6));
        if (m_state == 2) seen_led = int'(led);
    endtask

    task automatic press_start();
        start = 1'b1; cycle();
        start = 1'b0; cycle();
    endtask

    task automatic press_restart();
        restart = 1'b1; cycle();
        restart = 1'b0; cycle();
    endtask

    task automatic wait_state(input string tag, input int target, input int budget);
        int k = 0;
        while (m_state != target && k < budget) begin
            cycle();
            k++;
        end
        check_val(tag, int'(state), target);
    endtask

    function automatic logic [6:0] junk_upper(input int lvl);
        int j;
        j = $urandom & 127 & ~((1 << (BaseW + lvl)) - 1);
        return 7'(j);
    endfunction

    task automatic good_guess();
        guess = 7'(seen_led) | junk_upper(m_level);
        press_start();
    endtask

    initial begin
        rst = 1'b0; en = 1'b0; start = 1'b0; restart = 1'b0; guess = '0;
        seen_led = 0;
        repeat (2) cycle();
        check_val("reset_state", int'(state), 0);
        check_val("reset_led", int'(led), 0);
        rst = 1'b1; en = 1'b1;
        cycle();
        check_val("greet", int'(state), 1);

        // Start a game, then three correct guesses to WIN.
        start = 1'b1; cycle();
        check_val("show_entry", int'(state), 2);
        check_val("show_led_upper", int'(led) >> 5, 0);
        start = 1'b0;
        wait_state("to_input_l0", 3, 10);
        good_guess(); wait_state("to_input_l1", 3, 20);
        check_val("level_1", int'(level), 1);
        good_guess(); wait_state("to_input_l2", 3, 20);
        check_val("level_2", int'(level), 2);
        good_guess(); wait_state("to_win", 5, 20);
        check_val("win_flag", int'(win), 1);
        start = 1'b1; cycle(); start = 1'b0; cycle();
        check_val("win_holds", int'(state), 5);

        // Wrong guess at level 1.
        press_restart(); wait_state("rs_input", 3, 20);
        good_guess(); wait_state("l1_input", 3, 20);
        guess = 7'(seen_led) ^ 7'h01;
        press_start();
        check_val("miss_pulse", int'(miss), 1);
        check_val("tries_2", int'(tries_left), 2);
        wait_state("replay_input", 3, 20);

        // Three timeouts at level 0 lead to LOSE.
        press_restart();
        wait_state("timeout_lose", 6, 3 * (ShowN + TimeoutN + 1) + 10);
        check_val("lose_flag", int'(lose), 1);
        check_val("tries_0", int'(tries_left), 0);

        // Simultaneous start and restart at level 2: restart wins.
        press_restart(); wait_state("sim_in0", 3, 20);
        good_guess(); wait_state("sim_in1", 3, 20);
        good_guess(); wait_state("sim_in2", 3, 20);
        start = 1'b1; restart = 1'b1; cycle();
        check_val("sim_state", int'(state), 2);
        check_val("sim_level", int'(level), 0);
        check_val("sim_tries", int'(tries_left), 3);
        start = 1'b0; restart = 1'b0; cycle();
        check_val("sim_nomiss", int'(miss), 0);

        // en drop in INPUT, reset during SHOW.
        wait_state("en_in", 3, 20);
        en = 1'b0; cycle();
        check_val("en_idle", int'(state), 0);
        en = 1'b1; cycle();
        press_start();
        rst = 1'b0; cycle();
        check_val("rst_state", int'(state), 0);
        check_val("rst_led", int'(led), 0);
        rst = 1'b1;

        // Randomized stimulus against the model.
        for (int i = 0; i < 4000; i++) begin
            rst     = ($urandom_range(0, 499) != 0);
            en      = ($urandom_range(0, 199) != 0);
            start   = ($urandom_range(0, 3) == 0);
            restart = ($urandom_range(0, 59) == 0);
            if ($urandom_range(0, 1) == 0) guess = 7'(seen_led) | junk_upper(m_level);
            else guess = 7'($urandom);
            cycle();
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/game_level_ctrl.md
GAME_LEVEL_CTRL -- requirements
Module: game_level_ctrl

Interface
REQ-001 Parameters, one per line: name, default, meaning.
  - NUM_LEVELS, 3, number of game levels (1..8).
  - BASE_WIDTH, 5, target width of level 0 in bits.
  - MAX_TRIES, 3, guesses allowed per level (1..7).
  - SHOW_CYCLES, 50_000_000, cycles the target is shown on led.
  - TIMEOUT_CYCLES, 500_000_000, cycles allowed in INPUT before a forced miss.
  - SEED, 16'hACE1, LFSR reset value (nonzero).
REQ-002 Derived widths: MAXW = BASE_WIDTH+NUM_LEVELS-1; LW = clog2(NUM_LEVELS) (min 1); TW = clog2(MAX_TRIES+1).
REQ-003 Ports, one per line: name, direction, width, meaning.
  - clk, in, 1, the single clock.
  - rst, in, 1, reset, synchronous, active-low.
  - en, in, 1, game enable (master switch), level-sensitive.
  - start, in, 1, submit-guess button, raw level.
  - restart, in, 1, restart-game button, raw level.
  - guess, in, MAXW, switch value being guessed.
  - led, out, MAXW, target pattern during SHOW, else 0.
  - level, out, LW, current level, 0-based.
  - tries_left, out, TW, guesses remaining on the current level.
  - state, out, 3, current FSM state code.
  - miss, out, 1, one-cycle pulse on a wrong or timed-out guess.
  - win, out, 1, high while in WIN.
  - lose, out, 1, high while in LOSE.

Function
REQ-004 The block SHALL use these states: IDLE=0, GREET=1, SHOW=2, INPUT=3, JUDGE=4, WIN=5, LOSE=6.
REQ-005 start and restart SHALL each be registered, and the block SHALL act only on rising edges (in=1 while registered=0); holding a button SHALL count as a single event.
REQ-006 If en=0, the next state SHALL be IDLE from any state; this overrides all other transitions.
REQ-007 From IDLE with en=1, the next state SHALL be GREET.
REQ-008 In GREET, a start edge or a restart edge SHALL start a new game; otherwise the FSM SHALL hold.
REQ-009 A new game SHALL set level=0, tries_left=MAX_TRIES, sample a new target and enter SHOW.
REQ-010 A restart edge in SHOW, INPUT, WIN or LOSE SHALL start a new game (REQ-009).
REQ-011 When start and restart edges occur in the same cycle, restart SHALL win.
REQ-012 In SHOW, a down-counter SHALL run for exactly SHOW_CYCLES cycles, then the FSM SHALL enter INPUT.
REQ-013 In SHOW, led SHALL equal the target with all bits at index >= BASE_WIDTH+level forced to 0.
REQ-014 In INPUT, a start edge SHALL enter JUDGE on the next cycle.
REQ-015 In INPUT, if TIMEOUT_CYCLES elapse with no start edge, the FSM SHALL enter JUDGE with a forced-miss flag set.
REQ-016 The INPUT timer SHALL reload on every entry to INPUT.
REQ-017 JUDGE SHALL last one cycle.
REQ-018 In JUDGE, a hit SHALL be declared when the forced-miss flag is clear and guess equals target over bits [BASE_WIDTH+level-1:0]; upper bits SHALL be ignored.
REQ-019 On a hit with level < NUM_LEVELS-1: level SHALL increment, tries_left SHALL reload to MAX_TRIES, a new target SHALL be sampled, and the FSM SHALL enter SHOW.
REQ-020 On a hit with level = NUM_LEVELS-1, the FSM SHALL enter WIN.
REQ-021 On a miss, miss SHALL pulse for one cycle and tries_left SHALL decrement.
REQ-022 On a miss with tries_left = 1 before the decrement, the FSM SHALL enter LOSE.
REQ-023 On any other miss, the FSM SHALL re-enter SHOW with the same target and the same level.
REQ-024 A 16-bit Fibonacci LFSR (taps 16,14,13,11) SHALL shift every cycle, including in IDLE.
REQ-025 Target sampling SHALL latch lfsr[MAXW-1:0]; if the masked level value is 0, the block SHALL latch its bitwise inverse instead, so no target is 0.
REQ-026 WIN and LOSE SHALL hold until a restart edge or en=0.
REQ-027 win and lose SHALL be decoded directly from state.
REQ-028 A start edge in WIN or LOSE SHALL be ignored.

Reset
REQ-029 On a clk edge with rst=0: state=IDLE, level=0, tries_left=MAX_TRIES, all counters=0, target=0, lfsr=SEED, button registers=0.
REQ-030 During reset, led, miss, win and lose SHALL all be 0.
REQ-031 Reset asserted mid-game SHALL take effect on the next clk edge, overriding en and the buttons.

Structure
REQ-032 Shared package game_pkg SHALL hold the state encoding constants and the LFSR tap constant.
REQ-033 The LFSR SHALL be a sub-module named game_lfsr (ports: clk, rst, seed, q[15:0]); everything else SHALL live in game_level_ctrl.

Verification
Bench parameters for all scenarios: SHOW_CYCLES=4, TIMEOUT_CYCLES=16, defaults otherwise.
REQ-034 Reset, en=1, start edge -> GREET then SHOW; led nonzero with bits [6:5]=0 for exactly 4 cycles; then state=3.
REQ-035 Three correct guesses (bench copies led into guess) -> level steps 0,1,2; led width grows to 5, 6, then 7 bits; win=1; state=5.
REQ-036 Wrong guess at level 1 -> miss pulses once; tries_left 3->2; SHOW replays the identical target.
REQ-037 Three consecutive timeouts at level 0 with no start -> three miss pulses; tries_left 3,2,1,0; lose=1 after 3x(4+16+1)+ cycles.
REQ-038 start and restart edges in the same cycle during INPUT at level 2 -> level=0, tries_left=3, state=2, no miss pulse.
REQ-039 en dropped in INPUT -> IDLE next cycle, led=0; rst=0 during SHOW -> all outputs at reset values one edge later.
